pong_compositor: RTL

Per-pixel compositing and collision stage downstream of the ball and both paddle blocks. Each cycle it takes their `active`/`pixel` outputs for the current `hpos`/`vpos`, priority-muxes them over a side border and background, and delivers registered RGB to the HDMI controller with a fixed 2-cycle latency. Every frame it also accumulates ball/paddle overlaps and ball-at-goal-row events, and publishes them as per-frame flags at `fsync`, plus a saturating hit counter, for the game-control logic.

---
 rtl/pong_compositor_if.sv | 41 ++++
 rtl/pong_compositor.sv | 113 +++++++++++
 2 files changed

// File: rtl/pong_compositor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_compositor_if : per-pixel sprite inputs and composited/event outputs
// Rev 1.0
// ---------------------------------------------------------------------------
interface pong_compositor_if #(
    parameter int CNT_W = 8
);
    logic                    fsync;
    logic                    de;
    logic signed [11:0]      hpos;
    logic signed [11:0]      vpos;
    logic                    ball_active;
    logic [2:0][7:0]         ball_pixel;
    logic                    pad_top_active;
    logic [2:0][7:0]         pad_top_pixel;
    logic                    pad_bot_active;
    logic [2:0][7:0]         pad_bot_pixel;
    logic [2:0][7:0]         rgb_out;
    logic                    de_out;
    logic                    hit_top;
    logic                    hit_bot;
    logic                    goal_top;
    logic                    goal_bot;
    logic [CNT_W-1:0]        hit_count;

    modport master (
        output fsync, de, hpos, vpos,
        output ball_active, ball_pixel, pad_top_active, pad_top_pixel,
        output pad_bot_active, pad_bot_pixel,
        input  rgb_out, de_out, hit_top, hit_bot, goal_top, goal_bot, hit_count
    );

    modport slave (
        input  fsync, de, hpos, vpos,
        input  ball_active, ball_pixel, pad_top_active, pad_top_pixel,
        input  pad_bot_active, pad_bot_pixel,
        output rgb_out, de_out, hit_top, hit_bot, goal_top, goal_bot, hit_count
    );
endinterface
`default_nettype wire

// File: rtl/pong_compositor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_compositor : 2-stage pixel compositor with per-frame collision flags
// Rev 1.0
// ---------------------------------------------------------------------------
module pong_compositor #(
    parameter int          HRES         = 1280,
    parameter int          VRES         = 720,
    parameter int          BORDER_W     = 4,
    parameter logic [23:0] BORDER_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter int          CNT_W        = 8
) (
    input  wire logic         pixel_clk,
    input  wire logic         rst,
    pong_compositor_if.slave  bus
);
    localparam logic signed [11:0] c_ZERO     = 12'sd0;
    localparam logic signed [11:0] c_HRES     = 12'(HRES);
    localparam logic signed [11:0] c_VRES     = 12'(VRES);
    localparam logic signed [11:0] c_VLAST    = 12'(VRES - 1);
    localparam logic signed [11:0] c_BORDER_L = 12'(BORDER_W);
    localparam logic signed [11:0] c_BORDER_R = 12'(HRES - BORDER_W);

    logic            w_in_frame;
    logic            w_border;
    logic [3:0]      w_ev;
    logic [23:0]     w_rgb_next;
    logic [CNT_W:0]  w_sum;
    logic [CNT_W-1:0] w_count_next;

    logic            r_s1_de, r_s1_ball, r_s1_pt, r_s1_pb, r_s1_border;
    logic [23:0]     r_s1_ball_px, r_s1_pt_px, r_s1_pb_px;
    logic [23:0]     r_rgb;
    logic            r_de_out;
    logic [3:0]      r_acc;
    logic [3:0]      r_flag;
    logic [CNT_W-1:0] r_hit_count;

    // Signed compares so negative (blanking) coordinates never land in the frame
    assign w_in_frame = (bus.hpos >= c_ZERO) && (bus.hpos < c_HRES) &&
                        (bus.vpos >= c_ZERO) && (bus.vpos < c_VRES);
    assign w_border   = w_in_frame && ((bus.hpos < c_BORDER_L) || (bus.hpos >= c_BORDER_R));

    // Event bits: [0]=top overlap, [1]=bottom overlap, [2]=top goal, [3]=bottom goal
    assign w_ev[0] = bus.de & bus.ball_active & bus.pad_top_active;
    assign w_ev[1] = bus.de & bus.ball_active & bus.pad_bot_active;
    assign w_ev[2] = bus.de & bus.ball_active & (bus.vpos == c_ZERO);
    assign w_ev[3] = bus.de & bus.ball_active & (bus.vpos == c_VLAST);

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_s1_de      <= 1'b0;
            r_s1_ball    <= 1'b0;
            r_s1_pt      <= 1'b0;
            r_s1_pb      <= 1'b0;
            r_s1_border  <= 1'b0;
            r_s1_ball_px <= 24'h0;
            r_s1_pt_px   <= 24'h0;
            r_s1_pb_px   <= 24'h0;
            r_rgb        <= 24'h0;
            r_de_out     <= 1'b0;
        end else begin
            r_s1_de      <= bus.de;
            r_s1_ball    <= bus.ball_active;
            r_s1_pt      <= bus.pad_top_active;
            r_s1_pb      <= bus.pad_bot_active;
            r_s1_border  <= w_border;
            r_s1_ball_px <= bus.ball_pixel;
            r_s1_pt_px   <= bus.pad_top_pixel;
            r_s1_pb_px   <= bus.pad_bot_pixel;
            r_rgb        <= w_rgb_next;
            r_de_out     <= r_s1_de;
        end
    end

    always_comb begin
        w_rgb_next = BG_COLOR;
        if (!r_s1_de)         w_rgb_next = 24'h0;
        else if (r_s1_ball)   w_rgb_next = r_s1_ball_px;
        else if (r_s1_pt)     w_rgb_next = r_s1_pt_px;
        else if (r_s1_pb)     w_rgb_next = r_s1_pb_px;
        else if (r_s1_border) w_rgb_next = BORDER_COLOR;
    end

    // One extra bit of headroom catches the wrap before clamping
    assign w_sum        = {1'b0, r_hit_count} + {{CNT_W{1'b0}}, r_acc[0]}
                                              + {{CNT_W{1'b0}}, r_acc[1]};
    assign w_count_next = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_acc       <= 4'h0;
            r_flag      <= 4'h0;
            r_hit_count <= '0;
        end else if (bus.fsync) begin
            r_flag      <= r_acc;
            r_acc       <= w_ev;
            r_hit_count <= w_count_next;
        end else begin
            r_acc       <= r_acc | w_ev;
        end
    end

    assign bus.rgb_out   = r_rgb;
    assign bus.de_out    = r_de_out;
    assign bus.hit_top   = r_flag[0];
    assign bus.hit_bot   = r_flag[1];
    assign bus.goal_top  = r_flag[2];
    assign bus.goal_bot  = r_flag[3];
    assign bus.hit_count = r_hit_count;
endmodule
`default_nettype wire
